// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA input front end: scan states, select width
// and the active-low "nothing pressed" word.
package jamma_pkg;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_t;

  localparam int MAX_JOY_W = 64;
  localparam logic [MAX_JOY_W-1:0] JOY_RELEASED = '1;

  function automatic int sel_w(input int num_ch);
    return (num_ch <= 2) ? 1 : 2;
  endfunction

endpackage

// File: rtl/jamma_debounce.sv
// One channel's debouncer: publishes a sampled word once it has been seen
// DEBOUNCE_N more times in a row after first appearing.
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int JOY_W      = 8,
  parameter int DEBOUNCE_N = 3
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             smp_vld,
  input  logic [JOY_W-1:0] smp,
  output logic [JOY_W-1:0] word
);

  localparam int CNT_W = (DEBOUNCE_N > 0) ? $clog2(DEBOUNCE_N + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_N);

  logic [JOY_W-1:0] prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // A different sample restarts the run; an equal one extends it up to CNT_MAX.
  always_comb begin
    cnt_nxt = '0;
    if (smp == prev) begin
      cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      prev <= JOY_RELEASED[JOY_W-1:0];
      cnt  <= '0;
      word <= JOY_RELEASED[JOY_W-1:0];
    end else if (smp_vld) begin
      prev <= smp;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CNT_MAX) begin
        word <= smp;
      end
    end
  end

endmodule

// File: rtl/jamma_input_mux.sv
// JAMMA input front end: scans NUM_CH player channels over the shared JJOY bus,
// debounces each channel word, and synchronises/stretches the coin switches.
module jamma_input_mux
  import jamma_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int JOY_W      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int DEBOUNCE_N = 3,
  parameter int COIN_PULSE = 16,
  localparam int SEL_W     = sel_w(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [JOY_W-1:0]        JJOY,
  input  logic [JOY_W-1:0]        JOY_LOCAL,
  input  logic [NUM_CH-1:0]       JCOIN,
  output logic [SEL_W-1:0]        JSELECT,
  output logic [NUM_CH*JOY_W-1:0] joy_out,
  output logic [NUM_CH-1:0]       coin_out,
  output logic                    scan_done
);

  localparam int SLOT_W  = $clog2(SETTLE_CYC + 1);
  localparam int PULSE_W = $clog2(COIN_PULSE + 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_CH - 1);
  localparam logic [PULSE_W-1:0] PULSE_LEN = PULSE_W'(COIN_PULSE);

  scan_state_t         state;
  scan_state_t         state_nxt;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   slot_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic [JOY_W-1:0]    jjoy_m;
  logic [JOY_W-1:0]    jjoy_s;
  logic [NUM_CH-1:0]   coin_m;
  logic [NUM_CH-1:0]   coin_s;
  logic [NUM_CH-1:0]   coin_d;
  logic [NUM_CH-1:0]   coin_armed;
  logic [PULSE_W-1:0]  pulse_cnt [NUM_CH];

  // Synchronisers reset to the released level so no false coin edge follows reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      jjoy_m <= '1;
      jjoy_s <= '1;
      coin_m <= '1;
      coin_s <= '1;
      coin_d <= '1;
    end else begin
      jjoy_m <= JJOY;
      jjoy_s <= jjoy_m;
      coin_m <= JCOIN;
      coin_s <= coin_m;
      coin_d <= coin_s;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_SETTLE;
      slot    <= '0;
      JSELECT <= '0;
    end else begin
      state   <= state_nxt;
      slot    <= slot_nxt;
      JSELECT <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    sel_nxt   = JSELECT;
    scan_done = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (slot == SLOT_LAST) state_nxt = ST_SAMPLE;
        else                   slot_nxt  = slot + 1'b1;
      end
      ST_SAMPLE: begin
        state_nxt = ST_SETTLE;
        slot_nxt  = '0;
        sel_nxt   = (JSELECT == SEL_LAST) ? '0 : JSELECT + 1'b1;
        scan_done = (JSELECT == SEL_LAST);
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [JOY_W-1:0] smp;
    logic             smp_vld;
    assign smp     = (k == 0) ? (jjoy_s & JOY_LOCAL) : jjoy_s;
    assign smp_vld = (state == ST_SAMPLE) && (JSELECT == SEL_W'(k));

    jamma_debounce #(
      .JOY_W      (JOY_W),
      .DEBOUNCE_N (DEBOUNCE_N)
    ) u_debounce (
      .pclk    (CLK),
      .rst     (RESET),
      .smp_vld (smp_vld),
      .smp     (smp),
      .word    (joy_out[k*JOY_W +: JOY_W])
    );
  end

  // A falling edge fires only while armed; re-arming waits for pulse end and a released switch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coin_armed <= '1;
      for (int k = 0; k < NUM_CH; k++) pulse_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (coin_armed[k] && coin_d[k] && !coin_s[k]) begin
          pulse_cnt[k]  <= PULSE_LEN;
          coin_armed[k] <= 1'b0;
        end else if (pulse_cnt[k] != '0) begin
          pulse_cnt[k] <= pulse_cnt[k] - 1'b1;
        end else if (coin_s[k]) begin
          coin_armed[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    coin_out = '1;
    for (int k = 0; k < NUM_CH; k++) coin_out[k] = (pulse_cnt[k] == '0);
  end

endmodule
